regfile_sdp_ram: RTL and testbench



---
 rtl/regfile_sdp_ram.sv | 35 +++
 tb/tb_regfile_sdp_ram.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_sdp_ram.sv
// regfile_sdp_ram: 32x32 simple dual-port RAM, one write port, one registered read port, one clock
//   clock     - rising-edge clock for both ports
//   reset     - async active-high, clears only the read register q
//   data      - write data
//   rdaddress - read address, q follows one cycle later
//   wraddress - write address
//   wren      - write enable
//   q         - registered read data (old data on same-address read/write)
module regfile_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;
    always_comb rd_d = mem_q[rdaddress];
    // Memory has no reset; reset only blocks writes while it is held.
    always_ff @(posedge clock) begin
        if (!reset && wren) mem_q[wraddress] <= data;
    end
    // Read samples pre-write contents, so a same-address collision returns old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_q <= '0;
        else rd_q <= rd_d;
    end
    assign q = rd_q;
endmodule

// File: tb/tb_regfile_sdp_ram.sv
// tb_regfile_sdp_ram: directed-vector bench for regfile_sdp_ram
module tb_regfile_sdp_ram;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic [4:0]  rdaddress;
    logic [4:0]  wraddress;
    logic        wren;
    logic [31:0] q;
    int          n_vec = 0;
    int          n_bad = 0;

    regfile_sdp_ram dut (
        .clock(clock),
        .reset(reset),
        .data(data),
        .rdaddress(rdaddress),
        .wraddress(wraddress),
        .wren(wren),
        .q(q)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        data = '0;
        rdaddress = '0;
        wraddress = '0;
        wren = 1'b0;
        #1 chk("reset_q", q, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        // wren=0 leaves power-up zero in place
        wraddress = 5'd9; data = 32'hFFFFFFFF; wren = 1'b0; rdaddress = 5'd9;
        step();
        chk("nowr_first", q, 32'h0);
        step();
        chk("nowr_addr9", q, 32'h0);
        // basic write then read
        wraddress = 5'd7; data = 32'h12345678; wren = 1'b1; rdaddress = 5'd0;
        step();
        wren = 1'b0; rdaddress = 5'd7;
        step();
        chk("basic_rd7", q, 32'h12345678);
        // collision returns old data, new data on next read
        wraddress = 5'd3; data = 32'hAAAA0000; wren = 1'b1;
        step();
        data = 32'h5555FFFF; rdaddress = 5'd3;
        step();
        chk("collide_old", q, 32'hAAAA0000);
        wren = 1'b0;
        step();
        chk("collide_new", q, 32'h5555FFFF);
        // full sweep
        wren = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wraddress = 5'(i); data = 32'hC0DE0000 | i;
            step();
        end
        wren = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rdaddress = 5'(i);
            step();
            chk($sformatf("sweep_%0d", i), q, 32'hC0DE0000 | i);
        end
        // streaming reads of 0..15 while writing 16..31
        wren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rdaddress = 5'(i); wraddress = 5'(i + 16); data = 32'hBEEF0000 | i;
            step();
            chk($sformatf("stream_lo_%0d", i), q, 32'hC0DE0000 | i);
        end
        wren = 1'b0;
        for (int i = 16; i < 32; i++) begin
            rdaddress = 5'(i);
            step();
            chk($sformatf("stream_hi_%0d", i), q, 32'hBEEF0000 | (i - 16));
        end
        // reset mid-cycle clears q at once, blocks writes, keeps memory
        wraddress = 5'd12; data = 32'hDEADBEEF; wren = 1'b1;
        step();
        wren = 1'b0; rdaddress = 5'd12;
        step();
        chk("pre_reset_q", q, 32'hDEADBEEF);
        #2 reset = 1'b1;
        #1 chk("async_reset_q", q, 32'h0);
        wraddress = 5'd12; data = 32'h0; wren = 1'b1;
        step();
        chk("held_reset_q", q, 32'h0);
        reset = 1'b0; wren = 1'b0;
        step();
        chk("post_reset_rd12", q, 32'hDEADBEEF);
        rdaddress = 5'd7;
        step();
        chk("post_reset_rd7", q, 32'hC0DE0007);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
